// File: rtl/mdu_defs.sv
// Shared MD opcode encodings and default latencies for the E-stage multiply/divide unit.
package mdu_defs;

  localparam int MD_OP_W = 4;
  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MFHI  = 4'd5;
  localparam md_op_t MD_MFLO  = 4'd6;
  localparam md_op_t MD_MTHI  = 4'd7;
  localparam md_op_t MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, computes results at issue and
// commits them after a fixed busy period so the hazard unit can stall on busy.
module e_mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic        issue;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, q_mag, r_mag, sq, sr, uq, ur;
  logic [31:0] res_hi, res_lo;

  assign busy   = (cnt_q != '0);
  assign issue  = start && !busy && is_arith(md_op);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = (md_op == MD_MFHI) ? hi_q : lo_q;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly; a zero divisor is
  // replaced to keep X out of the datapath (that result is never committed).
  assign div_b = (b == '0) ? 32'd1 : b;
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = div_b[31] ? (~div_b + 32'd1) : div_b;
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign sq    = (a[31] ^ div_b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign sr    = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign uq    = a / div_b;
  assign ur    = a % div_b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (md_op)
      MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MD_DIV:   begin res_hi = sr;            res_lo = sq;           end
      MD_DIVU:  begin res_hi = ur;            res_lo = uq;           end
      default:  ;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (issue) begin
      cnt_d     = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      pend_we_d = !(is_div(md_op) && (b == '0));
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (md_op == MD_MTHI) begin
      hi_d = a;
    end else if (md_op == MD_MTLO) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results and busy timing.
module tb_e_mdu;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] va,
                       input logic [31:0] vb);
    md_op = op;
    start = st;
    a     = va;
    b     = vb;
  endtask

  // Issue in the current cycle, expect busy for n cycles with HI/LO held,
  // then the new values together with busy=0.
  task automatic run_arith(input string tag, input logic [3:0] op, input logic [31:0] va,
                           input logic [31:0] vb, input int n, input logic [31:0] e_hi,
                           input logic [31:0] e_lo);
    drive(op, 1'b1, va, vb);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(MD_NONE, 1'b0, 32'h0, 32'h0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      chk({tag, "_hold_hi"}, hi, m_hi);
    end
    tick();
    chk({tag, "_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  initial begin
    reset = 1'b0;
    drive(MD_NONE, 1'b0, 32'h0, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (3) tick();
    reset = 1'b1;

    // Reset state and reads
    md_op = MD_MFHI;
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mfhi", md_out, 32'h0);
    md_op = MD_MFLO;
    #1;
    chk("rst_mflo", md_out, 32'h0);

    // start with a non-arithmetic opcode is ignored
    drive(MD_MFLO, 1'b1, 32'h5, 32'h6);
    tick();
    drive(MD_NONE, 1'b0, 32'h0, 32'h0);
    chk("nonarith_busy", {31'b0, busy}, 32'd0);

    run_arith("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_arith("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_arith("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("divu",  MD_DIVU,  32'd7,         32'd2, 10, 32'd1, 32'd3);

    // MTHI/MTLO then divide by zero keeps them
    drive(MD_MTHI, 1'b0, 32'h1234_5678, 32'h0);
    tick();
    drive(MD_MTLO, 1'b0, 32'h9ABC_DEF0, 32'h0);
    tick();
    drive(MD_NONE, 1'b0, 32'h0, 32'h0);
    chk("mthi", hi, 32'h1234_5678);
    chk("mtlo", lo, 32'h9ABC_DEF0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
    run_arith("div0", MD_DIV, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
    run_arith("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // Interference while busy: second start and MTLO are both dropped
    drive(MD_MULT, 1'b1, 32'd3, 32'd4);
    tick();
    drive(MD_DIV, 1'b1, 32'd100, 32'd7);
    chk("intf_busy1", {31'b0, busy}, 32'd1);
    tick();
    drive(MD_MTLO, 1'b0, 32'h0000_DEAD, 32'h0);
    chk("intf_busy2", {31'b0, busy}, 32'd1);
    tick();
    drive(MD_NONE, 1'b0, 32'h0, 32'h0);
    chk("intf_mtlo_ign", lo, 32'h8000_0000);
    tick();
    tick();
    chk("intf_busy5", {31'b0, busy}, 32'd1);
    tick();
    chk("intf_done", {31'b0, busy}, 32'd0);
    chk("intf_hi", hi, 32'h0);
    chk("intf_lo", lo, 32'd12);
    tick();
    chk("intf_no_div", {31'b0, busy}, 32'd0);

    // MTHI in cycle C, MFHI reads new value in C+1
    md_op = MD_MFHI;
    #1;
    chk("mfhi_before", md_out, 32'h0);
    drive(MD_MTHI, 1'b0, 32'hCAFE_BABE, 32'h0);
    #1;
    chk("mthi_same_cyc_hi", hi, 32'h0);
    chk("mthi_same_cyc_out", md_out, 32'd12);
    tick();
    drive(MD_MFHI, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mfhi_after", md_out, 32'hCAFE_BABE);

    // Reset mid-divide abandons the op and clears HI/LO at once
    tick();
    drive(MD_DIVU, 1'b1, 32'd7, 32'd2);
    tick();
    drive(MD_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("middiv_busy", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'h0);
    chk("post_rst_lo", lo, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Execute-stage multiply/divide unit for the P6 five-stage MIPS pipeline. It sits beside the ALU in E and consumes the forwarded rs/rt operands plus the decoded MD opcode. It owns the HI/LO registers, models the multi-cycle latency of mult/div, and exports `busy` so the hazard unit stalls later HI/LO-dependent instructions in D. It also returns HI or LO to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu.
- DIV_CYCLES, 10, number of busy cycles for div/divu.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_op  in  4  E-stage MD opcode; encodings come from the shared package.
- start  in  1  one-cycle pulse, high while a mult/multu/div/divu is in E and not stalled.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- busy  out  1  high while an operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  HI when md_op is MFHI; LO otherwise.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, and the pending result is cleared. This applies at any time; an operation in flight is abandoned and HI/LO are not written.
- Ops:
  - NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - md_op is qualified by start only for the four arithmetic ops.
- Issue at cycle T, when start=1 and busy=0:
  - On the edge ending T, capture the result into internal pend_hi/pend_lo.
  - Load the counter with N, where N is MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0), a registered value. It is 1 during cycles T+1 through T+N.
- The counter decrements by 1 each edge while nonzero.
- On the edge where the counter goes from 1 to 0:
  - hi <= pend_hi and lo <= pend_lo.
  - The new values are visible in cycle T+N+1, together with busy=0.
- The hazard unit stalls on (start | busy). Stalling on start is its job, not this block's.
- Arithmetic:
  - MULT is the signed 32x32 product into 64 bits: hi = product[63:32], lo = product[31:0].
  - MULTU is the same, unsigned.
  - DIV is signed: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU is unsigned: lo = quotient, hi = remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (b==0): the op still runs for DIV_CYCLES with busy=1. At completion, HI and LO keep their prior values and no write occurs.
- MTHI/MTLO:
  - When busy=0, hi (or lo) <= a on the edge ending that cycle. There is no busy period.
  - When busy=1, the write is ignored. The hazard unit guarantees this never happens.
- MFHI/MFLO: md_out is combinational from the current hi/lo registers. There is no internal bypass of a same-cycle MTHI/MTLO.
- start while busy=1: ignored. The in-flight op completes unaffected.
- start with a non-arithmetic md_op: ignored.
- No back-to-back overlap. The earliest next issue is cycle T+N+1, which is also the first cycle that can read the new HI/LO.

Decomposition:
- Shared package mdu_defs (included header):
  - MD_OP width = 4.
  - Opcode constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
  - Default latency constants.
- Sub-modules: none required.
  - Result computation uses Verilog `*`, `/` and `%` on $signed/unsigned operands.
  - The timing model is a counter plus pend registers, all in one module.

Test Plan:
- Reset then read: after reset, with md_op=MFHI and then MFLO, md_out=0 and busy=0. Assert reset low mid-div; hi/lo stay 0 and busy drops immediately.
- Signed vs unsigned multiply, a=0xFFFFFFFF, b=2:
  - MULT gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU gives hi=0x00000001, lo=0xFFFFFFFE.
  - busy is high for exactly 5 cycles and the values appear in cycle T+6.
- Divide:
  - DIV with a=0xFFFFFFF9 (-7), b=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with a=7, b=2 gives lo=3, hi=1.
  - busy is high for exactly 10 cycles.
- Divide by zero and overflow:
  - MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIV with b=0: busy lasts 10 cycles and HI/LO are unchanged.
  - DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Interference during busy: issue MULT 3*4, then during busy pulse start with DIV 100/7 and apply MTLO 0xDEAD. Result is hi=0, lo=12, with completion still at T+6.
- MTHI/MFHI timing: MTHI with a=0xCAFEBABE in cycle C; md_out with MFHI reads 0xCAFEBABE in C+1 and the old value in C.
